// File: rtl/kgp_control_sequencer_pkg.sv
// rtl/kgp_control_sequencer_pkg.sv - state encodings, opcode/funct codes and ctrl_bus layout
package kgp_control_sequencer_pkg;

  localparam int OPC_W   = 6;
  localparam int FUNCT_W = 5;
  localparam int CTRL_W  = 23;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {PATH_ALU, PATH_LD, PATH_ST, PATH_BR, PATH_HALT} path_e;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00, OPC_ADDI = 6'h01, OPC_COMPI = 6'h02,
                               OPC_LD = 6'h03, OPC_ST = 6'h04, OPC_B = 6'h05, OPC_BCY = 6'h06,
                               OPC_BNCY = 6'h07, OPC_BZ = 6'h08, OPC_BNZ = 6'h09, OPC_BL = 6'h0A,
                               OPC_BR = 6'h0B, OPC_HALT = 6'h3F;

  localparam logic [FUNCT_W-1:0] FN_ADD = 5'h01, FN_AND = 5'h02, FN_XOR = 5'h03, FN_COMP = 5'h05,
                                 FN_SHI0 = 5'h08, FN_SHI1 = 5'h09, FN_SHI2 = 5'h0A,
                                 FN_SHR0 = 5'h0C, FN_SHR1 = 5'h0D, FN_SHR2 = 5'h0E;

  // Single-bit flags, MSB first, followed by 2-bit fields
  localparam int B_REGWRITE = 22, B_IMMSEL = 21, B_ALUSRC = 20, B_COMPENBL = 19,
                 B_SHIFTAMNTSEL = 18, B_SHIFTENBL = 17, B_SHORTBR = 16, B_LONGBR = 15,
                 B_MEMREAD = 14, B_MEMWRITE = 13, B_BRANCHREG = 12;
  localparam int F_ALUOP = 10, F_REGDST = 8, F_SHIFTTYPE = 6, F_BRANCHTYPE = 4,
                 F_JUMPTYPE = 2, F_MEMTOREG = 0;

  localparam logic [CTRL_W-1:0] WB_STROBES  = CTRL_W'(1) << B_REGWRITE;
  localparam logic [CTRL_W-1:0] MEM_STROBES = (CTRL_W'(1) << B_MEMREAD) | (CTRL_W'(1) << B_MEMWRITE);
  localparam logic [CTRL_W-1:0] STROBE_MASK = WB_STROBES | MEM_STROBES;

endpackage

// File: rtl/kgp_control_sequencer_decoder.sv
// rtl/kgp_control_sequencer_decoder.sv - combinational opcode/funct -> ctrl word, path class, illegal
module kgp_control_sequencer_decoder
  import kgp_control_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0]   opc_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [CTRL_W-1:0]  ctrl_word_o,
  output path_e              path_o,
  output logic               illegal_o
);

  logic [CTRL_W-1:0] w;
  path_e             path;
  logic              bad;

  always_comb begin
    w    = '0;
    path = PATH_ALU;
    bad  = 1'b0;
    case (opc_i)
      OPC_RTYPE: begin
        w[B_REGWRITE]    = 1'b1;
        w[F_REGDST +: 2] = 2'b01;
        case (funct_i)
          FN_ADD:  w[F_ALUOP +: 2] = 2'b01;
          FN_COMP: begin
            w[F_ALUOP +: 2] = 2'b01;
            w[B_COMPENBL]   = 1'b1;
          end
          FN_AND:  w[F_ALUOP +: 2] = 2'b10;
          FN_XOR:  w[F_ALUOP +: 2] = 2'b11;
          FN_SHI0, FN_SHI1, FN_SHI2: begin
            w[B_SHIFTENBL]      = 1'b1;
            w[F_SHIFTTYPE +: 2] = funct_i[1:0];
          end
          FN_SHR0, FN_SHR1, FN_SHR2: begin
            w[B_SHIFTENBL]      = 1'b1;
            w[B_SHIFTAMNTSEL]   = 1'b1;
            w[F_SHIFTTYPE +: 2] = funct_i[1:0];
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_COMPI: begin
        w[B_REGWRITE]   = 1'b1;
        w[B_IMMSEL]     = 1'b1;
        w[B_ALUSRC]     = 1'b1;
        w[F_ALUOP +: 2] = 2'b01;
        w[B_COMPENBL]   = (opc_i == OPC_COMPI);
      end
      OPC_LD, OPC_ST: begin
        w[B_IMMSEL]     = 1'b1;
        w[B_ALUSRC]     = 1'b1;
        w[F_ALUOP +: 2] = 2'b01;
        if (opc_i == OPC_LD) begin
          w[B_REGWRITE]      = 1'b1;
          w[B_MEMREAD]       = 1'b1;
          w[F_MEMTOREG +: 2] = 2'b01;
          path               = PATH_LD;
        end else begin
          w[B_MEMWRITE] = 1'b1;
          path          = PATH_ST;
        end
      end
      OPC_B: begin
        w[B_LONGBR]          = 1'b1;
        w[F_BRANCHTYPE +: 2] = 2'b01;
        w[F_JUMPTYPE +: 2]   = 2'b01;
        path                 = PATH_BR;
      end
      // Conditional branches: BranchType picks the flag, JumpType picks taken-if-set/clear
      OPC_BCY, OPC_BNCY, OPC_BZ, OPC_BNZ: begin
        w[B_SHORTBR]         = 1'b1;
        w[B_LONGBR]          = 1'b1;
        w[F_BRANCHTYPE +: 2] = (opc_i == OPC_BCY || opc_i == OPC_BNCY) ? 2'b11 : 2'b10;
        w[F_JUMPTYPE +: 2]   = (opc_i == OPC_BCY || opc_i == OPC_BZ) ? 2'b10 : 2'b11;
        path                 = PATH_BR;
      end
      OPC_BL: begin
        w[B_REGWRITE]        = 1'b1;
        w[B_LONGBR]          = 1'b1;
        w[F_BRANCHTYPE +: 2] = 2'b01;
        w[F_JUMPTYPE +: 2]   = 2'b01;
        w[F_REGDST +: 2]     = 2'b10;
        w[F_MEMTOREG +: 2]   = 2'b10;
      end
      OPC_BR: begin
        w[B_BRANCHREG]     = 1'b1;
        w[F_JUMPTYPE +: 2] = 2'b01;
        path               = PATH_BR;
      end
      OPC_HALT: path = PATH_HALT;
      default:  bad = 1'b1;
    endcase
    if (bad) begin
      w    = '0;
      path = PATH_BR;
    end
  end

  assign ctrl_word_o = w;
  assign path_o      = path;
  assign illegal_o   = bad;

endmodule

// File: rtl/kgp_control_sequencer.sv
// rtl/kgp_control_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB control sequencer for the datapath
// KGP_MEM_WAIT_EN: MEM stalls until mem_ready; otherwise MEM is a single cycle.
module kgp_control_sequencer
  import kgp_control_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl_bus,
  output logic              ir_we,
  output logic              pc_we,
  output logic              illegal,
  output logic              halted,
  output logic [2:0]        state_o
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_word_q, dec_word, bus_d;
  path_e             path_q, dec_path;
  logic              illegal_q, dec_illegal;
  logic              ir_we_d, pc_we_d, illegal_d, halted_d;
  logic              mem_done;

`ifdef KGP_MEM_WAIT_EN
  assign mem_done = mem_ready;
  logic unused_instr;
  assign unused_instr = ^instr[25:5];
`else
  assign mem_done = 1'b1;
  logic unused_inputs;
  assign unused_inputs = ^{instr[25:5], mem_ready};
`endif

  kgp_control_sequencer_decoder u_decoder (
    .opc_i       (instr[31:26]),
    .funct_i     (instr[4:0]),
    .ctrl_word_o (dec_word),
    .path_o      (dec_path),
    .illegal_o   (dec_illegal)
  );

  // Decode is captured with the IR so ctrl_bus stays stable until the next instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      ctrl_word_q <= '0;
      path_q      <= PATH_ALU;
      illegal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) begin
        ctrl_word_q <= dec_word;
        path_q      <= dec_path;
        illegal_q   <= dec_illegal;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bus_d     = '0;
    ir_we_d   = 1'b0;
    pc_we_d   = 1'b0;
    illegal_d = 1'b0;
    halted_d  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_we_d = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        bus_d   = ctrl_word_q & ~STROBE_MASK;
        state_d = (path_q == PATH_HALT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        bus_d = ctrl_word_q & ~STROBE_MASK;
        if (illegal_q) begin
          illegal_d = 1'b1;
          pc_we_d   = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          case (path_q)
            PATH_ALU:         state_d = ST_WB;
            PATH_LD, PATH_ST: state_d = ST_MEM;
            default: begin
              pc_we_d = 1'b1;
              state_d = ST_FETCH;
            end
          endcase
        end
      end
      ST_MEM: begin
        bus_d = (ctrl_word_q & ~STROBE_MASK) | (ctrl_word_q & MEM_STROBES);
        if (mem_done) begin
          if (path_q == PATH_ST) begin
            pc_we_d = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        bus_d   = (ctrl_word_q & ~STROBE_MASK) | (ctrl_word_q & WB_STROBES);
        pc_we_d = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted_d = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset masks outputs immediately so no strobe escapes from an aborted instruction
  assign ctrl_bus = rst ? '0 : bus_d;
  assign ir_we    = ir_we_d & ~rst;
  assign pc_we    = pc_we_d & ~rst;
  assign illegal  = illegal_d & ~rst;
  assign halted   = halted_d & ~rst;
  assign state_o  = state_q;

endmodule
